// File: rtl/basic_pipe_stream.sv
// basic_pipe_stream: two-stage valid/ready pipeline computing (a+b)*c per beat.
// It also keeps a running sum of the products within each group; a group is
// closed by a beat with last=1.
// Stage 1 registers a+b, c and last.
// Stage 2 registers the product, the group sum including that beat, and last.
// Backpressure from the consumer (i_ready) reaches o_ready combinationally.
// A drained stage and a refilled stage can therefore change on the same edge.
module basic_pipe_stream #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32  // must be at least 2*WIDTH+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_c,
  input  logic                 i_last,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [2*WIDTH:0]     o_result,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_last,
  output logic                 o_valid,
  input  logic                 i_ready
);

  localparam int PW = 2*WIDTH + 1;

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH:0]   s1_ab;
  logic [WIDTH-1:0] s1_c;
  logic             s1_last;

  // Stage 2 state
  logic                 s2_valid;
  logic [PW-1:0]        s2_prod;
  logic [ACC_WIDTH-1:0] s2_acc;
  logic                 s2_last;

  // Running sum of the group currently open; this is the only group state.
  logic [ACC_WIDTH-1:0] run_sum;

  logic                 adv1;
  logic                 adv2;
  logic [PW-1:0]        prod_new;
  logic [ACC_WIDTH-1:0] sum;

  // Advance conditions and stage-2 arithmetic on the beat currently held in stage 1
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    adv2     = !s2_valid || i_ready;
    adv1     = !s1_valid || adv2;
    prod_new = PW'(s1_ab) * PW'(s1_c);
    sum      = run_sum + ACC_WIDTH'(prod_new);  // wraps modulo 2^ACC_WIDTH
  end

  // Stage 1 loads whenever it is empty or its contents can move on
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data registers are reset too, so outputs read as 0 after reset, not X.
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ab    <= '0;
      s1_c     <= '0;
      s1_last  <= 1'b0;
    end else if (adv1) begin
      // NOTE: state is updated with non-blocking assignments, so every stage samples pre-edge values.
      s1_valid <= i_valid;
      s1_ab    <= {1'b0, i_a} + {1'b0, i_b};
      s1_c     <= i_c;
      s1_last  <= i_last;
    end
  end

  // Stage 2 loads when the output slot is empty or is being taken this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_acc   <= '0;
      s2_last  <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_prod  <= prod_new;
      s2_last  <= s1_last;
      if (s1_valid) s2_acc <= sum;
    end
  end

  // The group sum moves only when a real beat enters stage 2, and clears after a group's last beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_sum <= '0;
    end else if (adv2 && s1_valid) begin
      run_sum <= s1_last ? '0 : sum;
    end
  end

  assign o_ready  = adv1;
  assign o_valid  = s2_valid;
  assign o_result = s2_prod;
  assign o_acc    = s2_acc;
  assign o_last   = s2_last;

endmodule

// File: tb/tb_basic_pipe_stream.sv
// Bench for basic_pipe_stream (WIDTH=8, ACC_WIDTH=17, so accumulator wrap is reachable).
// It runs a directed vector table, hand sequences for backpressure and reset, and random traffic.
// A scoreboard computes each expected output from the accepted input beats in order.
module tb_basic_pipe_stream;

  localparam int W  = 8;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  i_a = '0;
  logic [W-1:0]  i_b = '0;
  logic [W-1:0]  i_c = '0;
  logic          i_last = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [2*W:0]  o_result;
  logic [AW-1:0] o_acc;
  logic          o_last;
  logic          o_valid;
  logic          i_ready = 1'b1;

  basic_pipe_stream #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_last(i_last), .i_valid(i_valid),
    .o_ready(o_ready),
    .o_result(o_result), .o_acc(o_acc), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the model's view is that each output beat is the exact
  // product of an accepted beat, and its group sum is modulo 2^AW.
  typedef struct {
    int result;
    int acc;
    bit last;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           msum = 0;
  int           n_out = 0;
  bit           hold_pend = 0;
  logic [2*W:0] hold_res;
  logic [AW-1:0] hold_acc;
  logic         hold_last;

  // Transfers are decided on the coming rising edge.
  // Values seen at the falling edge are exactly those values.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      msum      = 0;
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid",  32'(o_valid),  1);
        check("hold_result", 32'(o_result), 32'(hold_res));
        check("hold_acc",    32'(o_acc),    32'(hold_acc));
        check("hold_last",   32'(o_last),   32'(hold_last));
      end
      hold_pend = o_valid && !i_ready;
      hold_res  = o_result;
      hold_acc  = o_acc;
      hold_last = o_last;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          n_out++;
          check("sb_result", 32'(o_result), e.result);
          check("sb_acc",    32'(o_acc),    e.acc);
          check("sb_last",   32'(o_last),   32'(e.last));
        end
      end
      if (i_valid && o_ready) begin
        e.result = (int'(i_a) + int'(i_b)) * int'(i_c);
        msum     = (msum + e.result) % (1 << AW);
        e.acc    = msum;
        e.last   = i_last;
        sb.push_back(e);
        if (i_last) msum = 0;
      end
    end
  end

  typedef struct {
    int a, b, c;
    bit last;
    int res, acc;
    bit olast;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit pending;
    int idx, c, n0;

    vecs[0] = '{3, 4, 5, 1'b1, 35, 35, 1'b1};
    vecs[1] = '{255, 255, 255, 1'b1, 130050, 130050, 1'b1};
    vecs[2] = '{1, 1, 2, 1'b0, 4, 4, 1'b0};
    vecs[3] = '{2, 3, 4, 1'b0, 20, 24, 1'b0};
    vecs[4] = '{0, 1, 1, 1'b1, 1, 25, 1'b1};
    vecs[5] = '{1, 0, 3, 1'b1, 3, 3, 1'b1};
    vecs[6] = '{255, 255, 255, 1'b0, 130050, 130050, 1'b0};
    vecs[7] = '{255, 255, 255, 1'b1, 130050, 129028, 1'b1};

    // Reset state
    #12;
    check("rst_valid",  32'(o_valid),  0);
    check("rst_result", 32'(o_result), 0);
    check("rst_acc",    32'(o_acc),    0);
    check("rst_last",   32'(o_last),   0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_after", 32'(o_ready), 1);
    step();

    // Table: back-to-back beats with i_ready=1, each appearing two cycles later
    for (int cyc = 0; cyc < NV + 3; cyc++) begin
      if (cyc < NV) begin
        i_valid = 1'b1;
        i_a = W'(vecs[cyc].a); i_b = W'(vecs[cyc].b); i_c = W'(vecs[cyc].c);
        i_last = vecs[cyc].last;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      check("tbl_ready", 32'(o_ready), 1);
      if (cyc >= 2 && cyc - 2 < NV) begin
        check("tbl_valid",  32'(o_valid),  1);
        check("tbl_result", 32'(o_result), vecs[cyc-2].res);
        check("tbl_acc",    32'(o_acc),    vecs[cyc-2].acc);
        check("tbl_last",   32'(o_last),   32'(vecs[cyc-2].olast));
      end else begin
        check("tbl_idle_valid", 32'(o_valid), 0);
      end
      step();
    end

    // Backpressure: 6 beats, consumer stalls during cycles 3..6
    idx = 0; c = 0; n0 = n_out;
    while (idx < 6 && c < 40) begin
      i_ready = !(c >= 3 && c <= 6);
      i_valid = 1'b1;
      i_a = W'(idx + 1); i_b = W'(2 * idx); i_c = W'(3 + idx);
      i_last = (idx == 2 || idx == 5);
      @(negedge clk);
      if (c <= 7) check("bp_ready", 32'(o_ready), (c >= 3 && c <= 6) ? 0 : 1);
      if (o_ready) idx++;
      step();
      c++;
    end
    if (idx < 6) check("bp_accept_timeout", idx, 6);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (4) step();
    check("bp_delivered", n_out - n0, 6);
    check("bp_sb_empty", sb.size(), 0);

    // Reset while stalled with a partial group in flight
    i_ready = 1'b0;
    i_valid = 1'b1; i_a = 8'd1; i_b = 8'd1; i_c = 8'd1; i_last = 1'b0;
    step();
    i_a = 8'd2; i_b = 8'd2; i_c = 8'd2;
    step();
    i_valid = 1'b0;
    step();
    @(negedge clk);
    check("stall_full_ready", 32'(o_ready), 0);
    check("stall_full_valid", 32'(o_valid), 1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid",  32'(o_valid),  0);
    check("arst_result", 32'(o_result), 0);
    check("arst_acc",    32'(o_acc),    0);
    check("arst_ready",  32'(o_ready),  1);
    step();
    step();
    rst = 1'b1;
    i_ready = 1'b1;
    i_valid = 1'b1; i_a = 8'd2; i_b = 8'd2; i_c = 8'd2; i_last = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    @(negedge clk);
    check("post_rst_valid",  32'(o_valid),  1);
    check("post_rst_result", 32'(o_result), 8);
    check("post_rst_acc",    32'(o_acc),    8);
    check("post_rst_last",   32'(o_last),   1);
    step();

    // Random traffic against the scoreboard, with upstream holding on stall
    pending = 1'b0;
    for (int k = 0; k < 400; k++) begin
      i_ready = ($urandom_range(0, 99) < 70);
      if (!pending) begin
        i_valid = ($urandom_range(0, 99) < 75);
        i_a = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
        i_b = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
        i_c = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
        i_last = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      pending = i_valid && !o_ready;
      step();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (4) step();
    check("rand_sb_empty", sb.size(), 0);
    @(negedge clk);
    check("rand_idle_valid", 32'(o_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
